// File: rtl/cdb_arbiter_rr.sv
// rtl/cdb_arbiter_rr.sv - Common Data Bus arbiter: CH_N result channels merged into one registered stream
// Round-robin or fixed-priority (with starvation escape) selection, single output register with flush.
package cdb_pkg;
  localparam int XLEN       = 32;
  localparam int ROB_IDX_W  = 6;
  localparam int EXC_CODE_W = 4;

  typedef struct packed {
    logic [ROB_IDX_W-1:0]  rob_idx;
    logic [XLEN-1:0]       res_value;
    logic                  except_raised;
    logic [EXC_CODE_W-1:0] except_code;
  } cdb_data_t;
endpackage

module cdb_arbiter_rr
  import cdb_pkg::*;
#(
  parameter int CH_N      = 7,
  parameter int RR_EN     = 1,
  parameter int CNT_W     = 8,
  parameter int STARVE_TH = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [CH_N-1:0]           valid_i,
  output logic [CH_N-1:0]           ready_o,
  input  cdb_data_t [CH_N-1:0]      data_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output cdb_data_t                 data_o,
  output logic [$clog2(CH_N)-1:0]   grant_ch_o
);

  localparam int GW = $clog2(CH_N);

  logic [GW-1:0]    ptr;
  logic [CNT_W-1:0] cnt [CH_N];

  logic          out_free;
  logic          grant_en;
  logic [GW-1:0] grant_idx;

  logic          rr_hi_found;
  logic [GW-1:0] rr_hi_idx;
  logic [GW-1:0] rr_lo_idx;
  logic          st_found;
  logic [GW-1:0] st_idx;
  logic [GW-1:0] fp_idx;

  assign out_free = !valid_o || ready_i;
  assign grant_en = out_free && !flush_i && (|valid_i) && !rst_i;

  // Downward scans leave the lowest matching index in each candidate.
  always_comb begin
    rr_hi_found = 1'b0;
    rr_hi_idx   = '0;
    rr_lo_idx   = '0;
    st_found    = 1'b0;
    st_idx      = '0;
    fp_idx      = '0;
    for (int k = CH_N - 1; k >= 0; k--) begin
      if (valid_i[k]) begin
        rr_lo_idx = GW'(k);
        fp_idx    = GW'(k);
        if (k >= int'(ptr)) begin
          rr_hi_found = 1'b1;
          rr_hi_idx   = GW'(k);
        end
        if (int'(cnt[k]) >= STARVE_TH) begin
          st_found = 1'b1;
          st_idx   = GW'(k);
        end
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    if (RR_EN != 0) begin
      grant_idx = rr_hi_found ? rr_hi_idx : rr_lo_idx;
    end else begin
      grant_idx = st_found ? st_idx : fp_idx;
    end
  end

  always_comb begin
    ready_o = '0;
    for (int k = 0; k < CH_N; k++) begin
      ready_o[k] = grant_en && (grant_idx == GW'(k));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o    <= 1'b0;
      data_o     <= '0;
      grant_ch_o <= '0;
      ptr        <= '0;
    end else begin
      if (grant_en) begin
        valid_o    <= 1'b1;
        data_o     <= data_i[grant_idx];
        grant_ch_o <= grant_idx;
      end else if (flush_i || ready_i) begin
        valid_o <= 1'b0;
      end
      // Explicit compare keeps the wrap correct for non-power-of-2 channel counts.
      if (grant_en && (RR_EN != 0)) begin
        ptr <= (grant_idx == GW'(CH_N - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < CH_N; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CH_N; k++) begin
        if ((RR_EN != 0) || !valid_i[k] || ready_o[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] != {CNT_W{1'b1}}) begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter_rr.sv
// tb/tb_cdb_arbiter_rr.sv - self-checking bench for cdb_arbiter_rr
// Three instances: 7-ch round-robin, 5-ch round-robin, 3-ch fixed priority with STARVE_TH=4.
module tb_cdb_arbiter_rr;
  import cdb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [6:0] a_valid, a_ready;
  cdb_data_t [6:0] a_data;
  logic a_flush, a_ri, a_vo;
  cdb_data_t a_do;
  logic [2:0] a_g;

  logic [4:0] b_valid, b_ready;
  cdb_data_t [4:0] b_data;
  logic b_flush, b_ri, b_vo;
  cdb_data_t b_do;
  logic [2:0] b_g;

  logic [2:0] c_valid, c_ready;
  cdb_data_t [2:0] c_data;
  logic c_flush, c_ri, c_vo;
  cdb_data_t c_do;
  logic [1:0] c_g;

  cdb_arbiter_rr #(.CH_N(7), .RR_EN(1), .CNT_W(8), .STARVE_TH(64)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .valid_i(a_valid), .ready_o(a_ready),
    .data_i(a_data), .valid_o(a_vo), .ready_i(a_ri), .data_o(a_do), .grant_ch_o(a_g));

  cdb_arbiter_rr #(.CH_N(5), .RR_EN(1), .CNT_W(8), .STARVE_TH(64)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .valid_i(b_valid), .ready_o(b_ready),
    .data_i(b_data), .valid_o(b_vo), .ready_i(b_ri), .data_o(b_do), .grant_ch_o(b_g));

  cdb_arbiter_rr #(.CH_N(3), .RR_EN(0), .CNT_W(8), .STARVE_TH(4)) u_c (
    .clk_i(clk), .rst_i(rst), .flush_i(c_flush), .valid_i(c_valid), .ready_o(c_ready),
    .data_i(c_data), .valid_o(c_vo), .ready_i(c_ri), .data_o(c_do), .grant_ch_o(c_g));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic cdb_data_t mk(input int rob);
    cdb_data_t d;
    d.rob_idx       = rob[ROB_IDX_W-1:0];
    d.res_value     = $urandom;
    d.except_raised = 1'($urandom_range(0, 1));
    d.except_code   = 4'($urandom_range(0, 15));
    return d;
  endfunction

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pure modular search / counting, independent of RTL structure.
  function automatic int rr_pick(input logic [15:0] v, input int n, input int p);
    int c;
    for (int i = 0; i < n; i++) begin
      c = (p + i) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  int c_cnt [3];

  function automatic int fp_pick(input logic [2:0] v);
    for (int k = 0; k < 3; k++) if (v[k] && c_cnt[k] >= 4) return k;
    for (int k = 0; k < 3; k++) if (v[k]) return k;
    return -1;
  endfunction

  typedef struct {
    logic [4:0] valid;
    logic [4:0] exp_ready;
    int         exp_g;
  } b_vec_t;
  b_vec_t b_tab [7];

  int starve_exp [10] = '{1, 1, 1, 1, 4, 1, 1, 1, 1, 4};

  logic [6:0] ma_pv;
  cdb_data_t ma_pd [7];
  int ma_ptr, ma_och, ga;
  logic ma_ov;
  cdb_data_t ma_od;
  logic [2:0] mc_pv;
  cdb_data_t mc_pd [3];
  int mc_och, gc;
  logic mc_ov;
  cdb_data_t mc_od;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_valid = '1; a_flush = 0; a_ri = 0; a_data = '0;
    b_valid = '0; b_flush = 0; b_ri = 1; b_data = '0;
    c_valid = '0; c_flush = 0; c_ri = 1; c_data = '0;
    for (int k = 0; k < 7; k++) a_data[k] = mk(k);

    // Reset state, with inputs requesting service
    #12;
    chk("rst_a_valid_o", 64'(a_vo), 0);
    chk("rst_a_data_o", 64'(a_do), 0);
    chk("rst_a_grant", 64'(a_g), 0);
    chk("rst_a_ready_o", 64'(a_ready), 0);
    chk("rst_b_valid_o", 64'(b_vo), 0);
    chk("rst_c_valid_o", 64'(c_vo), 0);
    a_valid = '0;
    @(negedge clk);
    rst = 0;
    to_pos();

    // Round-robin fairness: all channels valid for 14 cycles
    a_valid = '1; a_ri = 1;
    for (int i = 0; i < 14; i++) begin
      to_neg();
      chk("rr_fair_ready", 64'(a_ready), 64'(1 << (i % 7)));
      to_pos();
      chk("rr_fair_valid", 64'(a_vo), 1);
      chk("rr_fair_grant", 64'(a_g), 64'(i % 7));
      chk("rr_fair_rob", 64'(a_do.rob_idx), 64'(i % 7));
    end
    a_valid = '0;
    to_pos();
    chk("rr_drain_valid", 64'(a_vo), 0);

    // Wrap-around on a 5-channel instance
    b_tab[0] = '{5'b01000, 5'b01000, 3};
    b_tab[1] = '{5'b00011, 5'b00001, 0};
    b_tab[2] = '{5'b00011, 5'b00010, 1};
    b_tab[3] = '{5'b10001, 5'b10000, 4};
    b_tab[4] = '{5'b10001, 5'b00001, 0};
    b_tab[5] = '{5'b00000, 5'b00000, 0};
    b_tab[6] = '{5'b11111, 5'b00010, 1};
    for (int i = 0; i < 7; i++) begin
      b_valid = b_tab[i].valid;
      for (int k = 0; k < 5; k++) b_data[k] = mk(10 + k);
      to_neg();
      chk("wrap_ready", 64'(b_ready), 64'(b_tab[i].exp_ready));
      to_pos();
      chk("wrap_valid_o", 64'(b_vo), 64'(b_tab[i].exp_ready != 0));
      if (b_tab[i].exp_ready != 0) begin
        chk("wrap_grant", 64'(b_g), 64'(b_tab[i].exp_g));
        chk("wrap_rob", 64'(b_do.rob_idx), 64'(10 + b_tab[i].exp_g));
      end
    end
    b_valid = '0;

    // Backpressure: hold rob_idx=5 for 3 cycles, then consume + regrant in one cycle
    a_valid = 7'b0100000; a_data[5] = mk(5); a_ri = 1;
    to_neg();
    chk("bp_first_ready", 64'(a_ready), 64'h20);
    to_pos();
    chk("bp_first_rob", 64'(a_do.rob_idx), 5);
    a_ri = 0; a_valid = 7'b0101001;
    a_data[0] = mk(30); a_data[3] = mk(33); a_data[5] = mk(35);
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("bp_hold_ready", 64'(a_ready), 0);
      to_pos();
      chk("bp_hold_valid", 64'(a_vo), 1);
      chk("bp_hold_rob", 64'(a_do.rob_idx), 5);
    end
    a_ri = 1;
    to_neg();
    chk("bp_release_ready", 64'(a_ready), 64'h01);
    to_pos();
    chk("bp_release_valid", 64'(a_vo), 1);
    chk("bp_release_rob", 64'(a_do.rob_idx), 30);
    chk("bp_release_grant", 64'(a_g), 0);
    a_valid = '0;
    to_pos();
    chk("bp_drain_valid", 64'(a_vo), 0);

    // Flush while the output register is full
    a_valid = 7'b0000010; a_data[1] = mk(41);
    to_pos();
    chk("fl_pre_valid", 64'(a_vo), 1);
    a_flush = 1; a_ri = 0; a_valid = 7'b0001000; a_data[3] = mk(43);
    to_neg();
    chk("fl_ready", 64'(a_ready), 0);
    to_pos();
    chk("fl_valid_o", 64'(a_vo), 0);
    a_flush = 0;
    to_neg();
    chk("fl_after_ready", 64'(a_ready), 64'h08);
    to_pos();
    chk("fl_after_valid", 64'(a_vo), 1);
    chk("fl_after_rob", 64'(a_do.rob_idx), 43);
    a_valid = '0; a_ri = 1;
    to_pos();

    // Starvation escape in fixed-priority mode
    c_valid = 3'b101; c_data[0] = mk(50); c_data[2] = mk(52);
    for (int i = 0; i < 10; i++) begin
      to_neg();
      chk("starve_ready", 64'(c_ready), 64'(starve_exp[i]));
      to_pos();
      chk("starve_grant", 64'(c_g), 64'(starve_exp[i] == 4 ? 2 : 0));
    end
    c_valid = '0;
    to_pos();

    // Asynchronous reset with a pending output
    a_valid = 7'b0000100; a_data[2] = mk(60); a_ri = 1;
    to_pos();
    chk("mrst_pre_valid", 64'(a_vo), 1);
    a_ri = 0; a_valid = '1;
    #2 rst = 1;
    #1;
    chk("mrst_valid_o", 64'(a_vo), 0);
    chk("mrst_data_o", 64'(a_do), 0);
    chk("mrst_ready_o", 64'(a_ready), 0);
    chk("mrst_grant", 64'(a_g), 0);
    @(negedge clk);
    a_valid = '0; a_ri = 1;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      to_pos();
      chk("mrst_idle_valid", 64'(a_vo), 0);
    end

    // Randomised run against the reference model, both arbitration modes
    ma_pv = '0; ma_ptr = 0; ma_ov = 0; ma_od = '0; ma_och = 0;
    mc_pv = '0; mc_ov = 0; mc_od = '0; mc_och = 0;
    for (int k = 0; k < 3; k++) c_cnt[k] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < 7; k++)
        if (!ma_pv[k] && $urandom_range(0, 1) == 1) begin ma_pv[k] = 1; ma_pd[k] = mk($urandom_range(0, 63)); end
      for (int k = 0; k < 3; k++)
        if (!mc_pv[k] && $urandom_range(0, 2) != 0) begin mc_pv[k] = 1; mc_pd[k] = mk($urandom_range(0, 63)); end
      a_valid = ma_pv; c_valid = mc_pv;
      for (int k = 0; k < 7; k++) a_data[k] = ma_pd[k];
      for (int k = 0; k < 3; k++) c_data[k] = mc_pd[k];
      a_ri = ($urandom_range(0, 3) != 0); a_flush = ($urandom_range(0, 19) == 0);
      c_ri = ($urandom_range(0, 3) != 0); c_flush = ($urandom_range(0, 19) == 0);
      ga = ((!ma_ov || a_ri) && !a_flush) ? rr_pick(16'(ma_pv), 7, ma_ptr) : -1;
      gc = ((!mc_ov || c_ri) && !c_flush) ? fp_pick(mc_pv) : -1;
      to_neg();
      chk("rnd_a_ready", 64'(a_ready), ga >= 0 ? 64'(1 << ga) : 0);
      chk("rnd_c_ready", 64'(c_ready), gc >= 0 ? 64'(1 << gc) : 0);
      to_pos();
      if (ga >= 0) begin
        ma_ov = 1; ma_od = ma_pd[ga]; ma_och = ga; ma_pv[ga] = 0; ma_ptr = (ga + 1) % 7;
      end else if (a_flush || a_ri) ma_ov = 0;
      for (int k = 0; k < 3; k++)
        if (!mc_pv[k] || k == gc) c_cnt[k] = 0;
        else if (c_cnt[k] < 255) c_cnt[k]++;
      if (gc >= 0) begin
        mc_ov = 1; mc_od = mc_pd[gc]; mc_och = gc; mc_pv[gc] = 0;
      end else if (c_flush || c_ri) mc_ov = 0;
      chk("rnd_a_valid", 64'(a_vo), 64'(ma_ov));
      chk("rnd_c_valid", 64'(c_vo), 64'(mc_ov));
      if (ma_ov) begin
        chk("rnd_a_data", 64'(a_do), 64'(ma_od));
        chk("rnd_a_grant", 64'(a_g), 64'(ma_och));
      end
      if (mc_ov) begin
        chk("rnd_c_data", 64'(c_do), 64'(mc_od));
        chk("rnd_c_grant", 64'(c_g), 64'(mc_och));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
